// File: rtl/ibex_fpu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ibex_fpu : single-cycle IEEE-754 binary32 execution unit (add/sub/mul/div,  |
// |            sqrt, min/max, int<->float) with an accrued exception register.  |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+

package ibex_fp_pkg;
  typedef enum logic [3:0] {
    FPU_NOP     = 4'd0,
    FPU_ADD     = 4'd1,
    FPU_SUB     = 4'd2,
    FPU_MUL     = 4'd3,
    FPU_DIV     = 4'd4,
    FPU_SQRT    = 4'd5,
    FPU_MIN     = 4'd6,
    FPU_MAX     = 4'd7,
    FPU_CVT_S_W = 4'd8,
    FPU_CVT_W_S = 4'd9
  } fpu_op_e;
endpackage

module ibex_fpu
  import ibex_fp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  fpu_op_e     fp_op,
  input  logic [2:0]  fp_rounding_mode,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rs3_i,
  input  logic [31:0] rs1_int_i,
  input  logic [31:0] instr,
  input  logic [4:0]  rd_addr_i,
  output logic [31:0] fp_regfile_wdata_o,
  output logic [4:0]  fp_regfile_addr_o,
  output logic        fp_regfile_write_o,
  output logic [31:0] int_regfile_wdata_o,
  output logic [4:0]  int_regfile_addr_o,
  output logic        int_regfile_write_o,
  output logic [4:0]  fflags_o
);

  localparam logic [2:0]  c_rm_rtz = 3'b001;
  localparam logic [2:0]  c_rm_rdn = 3'b010;
  localparam logic [2:0]  c_rm_rup = 3'b011;
  localparam logic [2:0]  c_rm_rmm = 3'b100;
  localparam logic [31:0] c_qnan   = 32'h7FC0_0000;
  // Flag vector layout {NV,DZ,OF,UF,NX}
  localparam logic [4:0]  c_fl_nv  = 5'b10000;
  localparam logic [4:0]  c_fl_dz  = 5'b01000;

  function automatic logic round_inc(input logic [2:0] rm, input logic sgn,
                                     input logic lsb, input logic g, input logic s);
    case (rm)
      c_rm_rtz: round_inc = 1'b0;
      c_rm_rdn: round_inc = sgn & (g | s);
      c_rm_rup: round_inc = ~sgn & (g | s);
      c_rm_rmm: round_inc = g;
      default:  round_inc = g & (s | lsb);
    endcase
  endfunction

  // v carries the significand with weight 1 at bit 48; returns {flags, result}.
  function automatic logic [36:0] round_pack(input logic sgn, input logic signed [11:0] exp_in,
                                             input logic [49:0] v, input logic [2:0] rm);
    logic [5:0]         p;
    logic [49:0]        vs;
    logic signed [11:0] e;
    logic [24:0]        m;
    logic               g, s, inc, to_max;
    p = '0;
    for (int i = 0; i < 50; i++) if (v[i]) p = 6'(i);
    vs  = v << (6'd49 - p);
    e   = exp_in + $signed({6'b0, p}) - 12'sd48;
    m   = {1'b0, vs[49:26]};
    g   = vs[25];
    s   = |vs[24:0];
    inc = round_inc(rm, sgn, m[0], g, s);
    m   = m + {24'b0, inc};
    if (m[24]) begin
      m = m >> 1;
      e = e + 12'sd1;
    end
    to_max = (rm == c_rm_rtz) | ((rm == c_rm_rdn) & ~sgn) | ((rm == c_rm_rup) & sgn);
    if (v == '0)
      round_pack = {5'b0, sgn, 31'b0};
    else if (e >= 12'sd255)
      round_pack = {5'b00101, to_max ? {sgn, 8'hFE, 23'h7FFFFF} : {sgn, 8'hFF, 23'h0}};
    else if (e <= 12'sd0)
      round_pack = {5'b00011, sgn, 31'b0};
    else
      round_pack = {4'b0, g | s, sgn, e[7:0], m[22:0]};
  endfunction

  logic w_unused;
  assign w_unused = ^{rs3_i, instr};

  // Operand unpack; subnormals flush to zero through w_*_zero.
  logic        w_a_sgn, w_b_sgn, w_a_zero, w_b_zero, w_a_inf, w_b_inf;
  logic        w_a_nan, w_b_nan, w_a_snan, w_b_snan;
  logic [7:0]  w_a_exp, w_b_exp;
  logic [23:0] w_a_man, w_b_man;

  assign w_a_sgn  = rs1_i[31];
  assign w_b_sgn  = rs2_i[31];
  assign w_a_exp  = rs1_i[30:23];
  assign w_b_exp  = rs2_i[30:23];
  assign w_a_zero = (w_a_exp == 8'd0);
  assign w_b_zero = (w_b_exp == 8'd0);
  assign w_a_man  = w_a_zero ? 24'd0 : {1'b1, rs1_i[22:0]};
  assign w_b_man  = w_b_zero ? 24'd0 : {1'b1, rs2_i[22:0]};
  assign w_a_inf  = (w_a_exp == 8'hFF) & (rs1_i[22:0] == 23'd0);
  assign w_b_inf  = (w_b_exp == 8'hFF) & (rs2_i[22:0] == 23'd0);
  assign w_a_nan  = (w_a_exp == 8'hFF) & (rs1_i[22:0] != 23'd0);
  assign w_b_nan  = (w_b_exp == 8'hFF) & (rs2_i[22:0] != 23'd0);
  assign w_a_snan = w_a_nan & ~rs1_i[22];
  assign w_b_snan = w_b_nan & ~rs2_i[22];

  // Add/sub: x is the larger magnitude, y is aligned with sticky folded into bit 0.
  logic        w_b_sgn_eff, w_swap, w_x_sgn, w_y_sgn, w_add_sgn;
  logic [7:0]  w_x_exp, w_y_exp, w_diff;
  logic [23:0] w_x_man, w_y_man;
  logic [49:0] w_x_full, w_y_full, w_y_sh, w_add_sum;

  assign w_b_sgn_eff = w_b_sgn ^ (fp_op == FPU_SUB);
  assign w_swap      = {w_b_exp, w_b_man} > {w_a_exp, w_a_man};
  assign w_x_sgn     = w_swap ? w_b_sgn_eff : w_a_sgn;
  assign w_y_sgn     = w_swap ? w_a_sgn : w_b_sgn_eff;
  assign w_x_exp     = w_swap ? w_b_exp : w_a_exp;
  assign w_y_exp     = w_swap ? w_a_exp : w_b_exp;
  assign w_x_man     = w_swap ? w_b_man : w_a_man;
  assign w_y_man     = w_swap ? w_a_man : w_b_man;
  assign w_diff      = w_x_exp - w_y_exp;
  assign w_x_full    = {1'b0, w_x_man, 25'b0};
  assign w_y_full    = {1'b0, w_y_man, 25'b0};
  assign w_y_sh      = (w_diff > 8'd48) ? {49'b0, |w_y_man}
                     : (w_y_full >> w_diff)
                       | {49'b0, |(w_y_full & ((50'd1 << w_diff) - 50'd1))};
  assign w_add_sum   = (w_x_sgn == w_y_sgn) ? w_x_full + w_y_sh : w_x_full - w_y_sh;
  assign w_add_sgn   = ((w_add_sum != '0) || (w_x_sgn == w_y_sgn)) ? w_x_sgn
                     : (fp_rounding_mode == c_rm_rdn);

  logic [47:0] w_mul_prod;
  assign w_mul_prod = {24'b0, w_a_man} * {24'b0, w_b_man};

  logic [25:0] w_div_q, w_div_rem;
  always_comb begin
    w_div_q   = '0;
    w_div_rem = {2'b0, w_a_man};
    for (int i = 25; i >= 0; i--) begin
      if (w_div_rem >= {2'b0, w_b_man}) begin
        w_div_q[i] = 1'b1;
        w_div_rem  = w_div_rem - {2'b0, w_b_man};
      end
      w_div_rem = w_div_rem << 1;
    end
  end

  // Odd unbiased exponent doubles the radicand so the halved exponent stays exact.
  logic        w_sq_odd;
  logic [8:0]  w_sq_esum;
  logic [49:0] w_sq_rad;
  logic [24:0] w_sq_root;
  logic [27:0] w_sq_rem, w_sq_trial;
  assign w_sq_odd  = ~w_a_exp[0];
  assign w_sq_esum = {1'b0, w_a_exp} + 9'd127 - {8'b0, w_sq_odd};
  assign w_sq_rad  = {(w_sq_odd ? {w_a_man, 1'b0} : {1'b0, w_a_man}), 25'b0};

  always_comb begin
    w_sq_root  = '0;
    w_sq_rem   = '0;
    w_sq_trial = '0;
    for (int i = 24; i >= 0; i--) begin
      w_sq_rem   = {w_sq_rem[25:0], w_sq_rad[2*i+1 -: 2]};
      w_sq_trial = {1'b0, w_sq_root, 2'b01};
      if (w_sq_rem >= w_sq_trial) begin
        w_sq_rem  = w_sq_rem - w_sq_trial;
        w_sq_root = {w_sq_root[23:0], 1'b1};
      end else begin
        w_sq_root = {w_sq_root[23:0], 1'b0};
      end
    end
  end

  logic [31:0] w_cvt_mag;
  assign w_cvt_mag = rs1_int_i[31] ? (~rs1_int_i + 32'd1) : rs1_int_i;

  logic w_a_lt_b;
  assign w_a_lt_b = (w_a_sgn != w_b_sgn) ? w_a_sgn
                  : (w_a_sgn ? (rs1_i[30:0] > rs2_i[30:0]) : (rs1_i[30:0] < rs2_i[30:0]));

  // Special-case resolution, otherwise select the operands of the shared rounder.
  logic               w_spec, w_p_sgn;
  logic [31:0]        w_spec_res;
  logic [4:0]         w_spec_flags;
  logic signed [11:0] w_p_exp;
  logic [49:0]        w_p_v;
  logic               w_mul_sgn;
  assign w_mul_sgn = w_a_sgn ^ w_b_sgn;

  always_comb begin
    w_spec       = 1'b0;
    w_spec_res   = '0;
    w_spec_flags = '0;
    w_p_sgn      = 1'b0;
    w_p_exp      = '0;
    w_p_v        = '0;
    case (fp_op)
      FPU_ADD, FPU_SUB: begin
        w_spec = 1'b1;
        if (w_a_nan | w_b_nan) begin
          w_spec_res   = c_qnan;
          w_spec_flags = (w_a_snan | w_b_snan) ? c_fl_nv : 5'b0;
        end else if (w_a_inf & w_b_inf & (w_a_sgn != w_b_sgn_eff)) begin
          w_spec_res   = c_qnan;
          w_spec_flags = c_fl_nv;
        end else if (w_a_inf) begin
          w_spec_res = {w_a_sgn, 8'hFF, 23'b0};
        end else if (w_b_inf) begin
          w_spec_res = {w_b_sgn_eff, 8'hFF, 23'b0};
        end else begin
          w_spec  = 1'b0;
          w_p_sgn = w_add_sgn;
          w_p_exp = $signed({4'b0, w_x_exp});
          w_p_v   = w_add_sum;
        end
      end
      FPU_MUL: begin
        w_spec = 1'b1;
        if (w_a_nan | w_b_nan) begin
          w_spec_res   = c_qnan;
          w_spec_flags = (w_a_snan | w_b_snan) ? c_fl_nv : 5'b0;
        end else if ((w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
          w_spec_res   = c_qnan;
          w_spec_flags = c_fl_nv;
        end else if (w_a_inf | w_b_inf) begin
          w_spec_res = {w_mul_sgn, 8'hFF, 23'b0};
        end else begin
          w_spec  = 1'b0;
          w_p_sgn = w_mul_sgn;
          w_p_exp = $signed({4'b0, w_a_exp}) + $signed({4'b0, w_b_exp}) - 12'sd127;
          w_p_v   = {w_mul_prod, 2'b0};
        end
      end
      FPU_DIV: begin
        w_spec = 1'b1;
        if (w_a_nan | w_b_nan) begin
          w_spec_res   = c_qnan;
          w_spec_flags = (w_a_snan | w_b_snan) ? c_fl_nv : 5'b0;
        end else if ((w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
          w_spec_res   = c_qnan;
          w_spec_flags = c_fl_nv;
        end else if (w_a_inf) begin
          w_spec_res = {w_mul_sgn, 8'hFF, 23'b0};
        end else if (w_b_zero) begin
          w_spec_res   = {w_mul_sgn, 8'hFF, 23'b0};
          w_spec_flags = c_fl_dz;
        end else if (w_b_inf | w_a_zero) begin
          w_spec_res = {w_mul_sgn, 31'b0};
        end else begin
          w_spec  = 1'b0;
          w_p_sgn = w_mul_sgn;
          w_p_exp = $signed({4'b0, w_a_exp}) - $signed({4'b0, w_b_exp}) + 12'sd127;
          w_p_v   = {1'b0, w_div_q, 22'b0, |w_div_rem};
        end
      end
      FPU_SQRT: begin
        w_spec = 1'b1;
        if (w_a_nan) begin
          w_spec_res   = c_qnan;
          w_spec_flags = w_a_snan ? c_fl_nv : 5'b0;
        end else if (w_a_zero) begin
          w_spec_res = {w_a_sgn, 31'b0};
        end else if (w_a_sgn) begin
          w_spec_res   = c_qnan;
          w_spec_flags = c_fl_nv;
        end else if (w_a_inf) begin
          w_spec_res = {1'b0, 8'hFF, 23'b0};
        end else begin
          w_spec  = 1'b0;
          w_p_exp = $signed({4'b0, w_sq_esum[8:1]});
          w_p_v   = {1'b0, w_sq_root, 23'b0, |w_sq_rem};
        end
      end
      FPU_MIN, FPU_MAX: begin
        w_spec       = 1'b1;
        w_spec_flags = (w_a_snan | w_b_snan) ? c_fl_nv : 5'b0;
        if (w_a_nan & w_b_nan)           w_spec_res = c_qnan;
        else if (w_a_nan)                w_spec_res = rs2_i;
        else if (w_b_nan)                w_spec_res = rs1_i;
        else if (w_a_lt_b ^ (fp_op == FPU_MAX)) w_spec_res = rs1_i;
        else                             w_spec_res = rs2_i;
      end
      FPU_CVT_S_W: begin
        w_p_sgn = rs1_int_i[31];
        w_p_exp = 12'sd175;
        w_p_v   = {18'b0, w_cvt_mag};
      end
      default: ;
    endcase
  end

  logic [36:0] w_rnd;
  logic [31:0] w_fp_res;
  logic [4:0]  w_fp_flags;
  assign w_rnd      = round_pack(w_p_sgn, w_p_exp, w_p_v, fp_rounding_mode);
  assign w_fp_res   = w_spec ? w_spec_res : w_rnd[31:0];
  assign w_fp_flags = w_spec ? w_spec_flags : w_rnd[36:32];

  // Float to signed int32: 32 fraction bits below the integer part feed the rounder.
  logic signed [11:0] w_cv_e;
  logic [5:0]         w_cv_sh;
  logic [63:0]        w_cv_fx;
  logic [31:0]        w_cv_ip, w_int_res;
  logic               w_cv_g, w_cv_s;
  logic [32:0]        w_cv_mag;
  logic [4:0]         w_int_flags;

  assign w_cv_e  = $signed({4'b0, w_a_exp}) - 12'sd127;
  assign w_cv_sh = 6'(w_cv_e + 12'sd9);
  assign w_cv_fx = {40'b0, w_a_man} << w_cv_sh;

  always_comb begin
    w_int_res   = '0;
    w_int_flags = '0;
    w_cv_ip     = '0;
    w_cv_g      = 1'b0;
    w_cv_s      = 1'b0;
    w_cv_mag    = '0;
    if (w_a_nan) begin
      w_int_res   = 32'h7FFF_FFFF;
      w_int_flags = c_fl_nv;
    end else if (w_a_inf | (w_cv_e > 12'sd31)) begin
      w_int_res   = w_a_sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      w_int_flags = c_fl_nv;
    end else if (!w_a_zero) begin
      if (w_cv_e < -12'sd2) begin
        w_cv_s = 1'b1;
      end else begin
        w_cv_ip = w_cv_fx[63:32];
        w_cv_g  = w_cv_fx[31];
        w_cv_s  = |w_cv_fx[30:0];
      end
      w_cv_mag = {1'b0, w_cv_ip}
               + {32'b0, round_inc(fp_rounding_mode, w_a_sgn, w_cv_ip[0], w_cv_g, w_cv_s)};
      if (!w_a_sgn && (w_cv_mag > 33'h0_7FFF_FFFF)) begin
        w_int_res   = 32'h7FFF_FFFF;
        w_int_flags = c_fl_nv;
      end else if (w_a_sgn && (w_cv_mag > 33'h0_8000_0000)) begin
        w_int_res   = 32'h8000_0000;
        w_int_flags = c_fl_nv;
      end else begin
        w_int_res   = w_a_sgn ? (~w_cv_mag[31:0] + 32'd1) : w_cv_mag[31:0];
        w_int_flags = {4'b0, w_cv_g | w_cv_s};
      end
    end
  end

  logic w_is_fp, w_is_int;
  assign w_is_fp  = (fp_op == FPU_ADD) | (fp_op == FPU_SUB) | (fp_op == FPU_MUL)
                  | (fp_op == FPU_DIV) | (fp_op == FPU_SQRT) | (fp_op == FPU_MIN)
                  | (fp_op == FPU_MAX) | (fp_op == FPU_CVT_S_W);
  assign w_is_int = (fp_op == FPU_CVT_W_S);

  assign fp_regfile_wdata_o  = w_is_fp ? w_fp_res : 32'd0;
  assign fp_regfile_addr_o   = rd_addr_i;
  assign fp_regfile_write_o  = w_is_fp & ~rst_i;
  assign int_regfile_wdata_o = w_is_int ? w_int_res : 32'd0;
  assign int_regfile_addr_o  = rd_addr_i;
  assign int_regfile_write_o = w_is_int & ~rst_i;

  logic [4:0] r_fflags;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      r_fflags <= '0;
    else if (fp_op != FPU_NOP)
      r_fflags <= r_fflags | (w_is_fp ? w_fp_flags : 5'b0) | (w_is_int ? w_int_flags : 5'b0);
  end
  assign fflags_o = r_fflags;

endmodule
`default_nettype wire

// File: tb/tb_ibex_fpu.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ibex_fpu : directed vectors with hand-computed results for ibex_fpu.     |
// | Revision    : 1.0                                                           |
// +-----------------------------------------------------------------------------+
module tb_ibex_fpu;
  import ibex_fp_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  fpu_op_e     fp_op;
  logic [2:0]  fp_rounding_mode;
  logic [31:0] rs1_i, rs2_i, rs3_i, rs1_int_i, instr;
  logic [4:0]  rd_addr_i;
  logic [31:0] fp_regfile_wdata_o, int_regfile_wdata_o;
  logic [4:0]  fp_regfile_addr_o, int_regfile_addr_o, fflags_o;
  logic        fp_regfile_write_o, int_regfile_write_o;

  int n_asserts = 0;
  int n_fail    = 0;

  ibex_fpu dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .fp_op               (fp_op),
    .fp_rounding_mode    (fp_rounding_mode),
    .rs1_i               (rs1_i),
    .rs2_i               (rs2_i),
    .rs3_i               (rs3_i),
    .rs1_int_i           (rs1_int_i),
    .instr               (instr),
    .rd_addr_i           (rd_addr_i),
    .fp_regfile_wdata_o  (fp_regfile_wdata_o),
    .fp_regfile_addr_o   (fp_regfile_addr_o),
    .fp_regfile_write_o  (fp_regfile_write_o),
    .int_regfile_wdata_o (int_regfile_wdata_o),
    .int_regfile_addr_o  (int_regfile_addr_o),
    .int_regfile_write_o (int_regfile_write_o),
    .fflags_o            (fflags_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_asserts++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic apply(input fpu_op_e op, input logic [2:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ia, input logic [4:0] rd);
    @(negedge clk_i);
    fp_op            = op;
    fp_rounding_mode = rm;
    rs1_i            = a;
    rs2_i            = b;
    rs1_int_i        = ia;
    rd_addr_i        = rd;
    #1;
  endtask

  initial begin
    rst_i            = 1'b1;
    fp_op            = FPU_ADD;
    fp_rounding_mode = 3'b000;
    rs1_i            = 32'h4120_0000;
    rs2_i            = 32'h4023_D70A;
    rs3_i            = 32'hDEAD_BEEF;
    rs1_int_i        = 32'd0;
    instr            = 32'h0;
    rd_addr_i        = 5'd1;
    #2;
    chk("rst_fflags", {27'b0, fflags_o}, 32'd0);
    chk("rst_fp_write", {31'b0, fp_regfile_write_o}, 32'd0);
    chk("rst_comb_wdata", fp_regfile_wdata_o, 32'h4148_F5C2);
    @(negedge clk_i);
    rst_i = 1'b0;

    apply(FPU_ADD, 3'b000, 32'h4120_0000, 32'h4023_D70A, 32'd0, 5'd3);
    chk("add_wdata", fp_regfile_wdata_o, 32'h4148_F5C2);
    chk("add_addr", {27'b0, fp_regfile_addr_o}, 32'd3);
    chk("add_fp_write", {31'b0, fp_regfile_write_o}, 32'd1);
    chk("add_int_write", {31'b0, int_regfile_write_o}, 32'd0);
    apply(FPU_SUB, 3'b000, 32'h4120_0000, 32'h4023_D70A, 32'd0, 5'd4);
    chk("sub_wdata", fp_regfile_wdata_o, 32'h40EE_147B);
    apply(FPU_ADD, 3'b000, 32'h4148_F5C2, 32'h40EE_147B, 32'd0, 5'd5);
    chk("add20_wdata", fp_regfile_wdata_o, 32'h41A0_0000);
    apply(FPU_MUL, 3'b000, 32'h4120_0000, 32'h4120_0000, 32'd0, 5'd6);
    chk("mul_wdata", fp_regfile_wdata_o, 32'h42C8_0000);
    apply(FPU_DIV, 3'b000, 32'h41A0_0000, 32'h4120_0000, 32'd0, 5'd7);
    chk("div_wdata", fp_regfile_wdata_o, 32'h4000_0000);
    apply(FPU_SQRT, 3'b000, 32'h42C8_0000, 32'h0, 32'd0, 5'd8);
    chk("sqrt_wdata", fp_regfile_wdata_o, 32'h4120_0000);
    apply(FPU_MIN, 3'b000, 32'h4023_D70A, 32'h4120_0000, 32'd0, 5'd9);
    chk("min_wdata", fp_regfile_wdata_o, 32'h4023_D70A);
    apply(FPU_MAX, 3'b000, 32'h4023_D70A, 32'h4120_0000, 32'd0, 5'd9);
    chk("max_wdata", fp_regfile_wdata_o, 32'h4120_0000);
    apply(FPU_NOP, 3'b000, 32'h4023_D70A, 32'h4120_0000, 32'd0, 5'd9);
    chk("nop_fp_write", {31'b0, fp_regfile_write_o}, 32'd0);
    chk("nop_int_write", {31'b0, int_regfile_write_o}, 32'd0);
    chk("nop_fp_wdata", fp_regfile_wdata_o, 32'd0);
    apply(FPU_MUL, 3'b000, 32'h7F00_0000, 32'h4000_0000, 32'd0, 5'd10);
    chk("ovf_rne", fp_regfile_wdata_o, 32'h7F80_0000);
    apply(FPU_MUL, 3'b001, 32'h7F00_0000, 32'h4000_0000, 32'd0, 5'd10);
    chk("ovf_rtz", fp_regfile_wdata_o, 32'h7F7F_FFFF);
    apply(FPU_SQRT, 3'b000, 32'h8000_0000, 32'h0, 32'd0, 5'd11);
    chk("sqrt_neg_zero", fp_regfile_wdata_o, 32'h8000_0000);
    chk("fflags_accum_ofnx", {27'b0, fflags_o}, 32'h0000_0005);

    rst_i = 1'b1;
    #1;
    chk("fflags_clear1", {27'b0, fflags_o}, 32'd0);
    rst_i = 1'b0;

    apply(FPU_DIV, 3'b000, 32'h3F80_0000, 32'h0000_0000, 32'd0, 5'd12);
    chk("div_by_zero", fp_regfile_wdata_o, 32'h7F80_0000);
    apply(FPU_SQRT, 3'b000, 32'hBF80_0000, 32'h0, 32'd0, 5'd13);
    chk("sqrt_neg", fp_regfile_wdata_o, 32'h7FC0_0000);
    apply(FPU_SUB, 3'b000, 32'h7F80_0000, 32'h7F80_0000, 32'd0, 5'd14);
    chk("inf_minus_inf", fp_regfile_wdata_o, 32'h7FC0_0000);
    apply(FPU_MIN, 3'b000, 32'h7FC0_0000, 32'h4040_0000, 32'd0, 5'd15);
    chk("min_qnan", fp_regfile_wdata_o, 32'h4040_0000);
    apply(FPU_NOP, 3'b000, 32'h0, 32'h0, 32'd0, 5'd0);
    chk("fflags_special", {27'b0, fflags_o}, 32'h0000_0018);
    rst_i = 1'b1;
    #1;
    chk("fflags_clear2", {27'b0, fflags_o}, 32'd0);
    rst_i = 1'b0;

    apply(FPU_CVT_S_W, 3'b000, 32'h0, 32'h0, 32'd250, 5'd16);
    chk("cvt_s_w", fp_regfile_wdata_o, 32'h437A_0000);
    chk("cvt_s_w_fp_write", {31'b0, fp_regfile_write_o}, 32'd1);
    apply(FPU_CVT_W_S, 3'b000, 32'h4023_D70A, 32'h0, 32'd0, 5'd17);
    chk("cvt_w_s_rne", int_regfile_wdata_o, 32'd3);
    chk("cvt_w_s_int_addr", {27'b0, int_regfile_addr_o}, 32'd17);
    chk("cvt_w_s_int_write", {31'b0, int_regfile_write_o}, 32'd1);
    chk("cvt_w_s_fp_write", {31'b0, fp_regfile_write_o}, 32'd0);
    apply(FPU_CVT_W_S, 3'b001, 32'h4023_D70A, 32'h0, 32'd0, 5'd17);
    chk("cvt_w_s_rtz", int_regfile_wdata_o, 32'd2);
    apply(FPU_CVT_W_S, 3'b000, 32'hC023_D70A, 32'h0, 32'd0, 5'd17);
    chk("cvt_w_s_neg", int_regfile_wdata_o, 32'hFFFF_FFFD);
    apply(FPU_CVT_W_S, 3'b000, 32'h4F80_0000, 32'h0, 32'd0, 5'd18);
    chk("cvt_w_s_sat", int_regfile_wdata_o, 32'h7FFF_FFFF);
    apply(FPU_NOP, 3'b000, 32'h0, 32'h0, 32'd0, 5'd0);
    chk("fflags_cvt", {27'b0, fflags_o}, 32'h0000_0011);
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;

    apply(FPU_ADD, 3'b000, 32'h3F80_0000, 32'h3380_0000, 32'd0, 5'd19);
    chk("round_rne", fp_regfile_wdata_o, 32'h3F80_0000);
    apply(FPU_ADD, 3'b011, 32'h3F80_0000, 32'h3380_0000, 32'd0, 5'd19);
    chk("round_rup", fp_regfile_wdata_o, 32'h3F80_0001);
    apply(FPU_NOP, 3'b000, 32'h0, 32'h0, 32'd0, 5'd0);
    chk("fflags_nx", {27'b0, fflags_o}, 32'h0000_0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
